// File: rtl/nios_debug_vjtag_host.sv
// ----------------------------------------------------------------------------
// nios_debug_vjtag_host
//
// Host-side initiator for the Nios II debug slave's virtual-JTAG port. It takes
// one IR/DR scan command at a time, walks the virtual TAP through
// UIR -> CDR -> SDR (DR_W bits) -> E1DR, and returns the DR word captured
// from vji_tdo. vji_tck is a registered data output derived from clk.
//
// Parameters
//   TCK_DIV : clk cycles per vji_tck half-period (>= 1)
//   DR_W    : data-register scan length
//   IR_W    : virtual IR width
//
// Ports
//   clk, reset_n        : system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_ir, cmd_data    : virtual IR and DR value (DR shifted LSB first)
//   rsp_valid, rsp_data : one-cycle response pulse with captured DR word
//   vji_tck, vji_tdi    : generated test clock and serial data to the slave
//   vji_tdo             : serial data from the slave
//   vji_ir_in           : virtual IR presented to the slave
//   vji_rti/uir/cdr/sdr/e1dr : one-hot virtual state indicators
//   o_dbg_state         : current FSM state encoding
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, so cmd_valid
// asserted during a scan is ignored. rsp_valid is a single-cycle pulse with
// no back-pressure; rsp_data then holds until the next scan's first sample.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module nios_debug_vjtag_host #(
  parameter int TCK_DIV = 2,
  parameter int DR_W    = 38,
  parameter int IR_W    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [DR_W-1:0] rsp_data,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  output logic            vji_rti,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_e1dr,
  output logic [2:0]      o_dbg_state
);

  localparam int PH_W  = $clog2(2 * TCK_DIV);
  localparam int BIT_W = $clog2(DR_W);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * TCK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(TCK_DIV);
  // Last cycle of the low half: the edge ending it raises vji_tck.
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_E1DR = 3'd4
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [BIT_W-1:0]  r_bit;
  logic [IR_W-1:0]   r_ir;
  logic [DR_W-1:0]   r_data;
  logic [DR_W-1:0]   r_rsp;
  logic              r_tck;
  logic              r_tdi;
  logic              r_rti;
  logic              r_uir;
  logic              r_cdr;
  logic              r_sdr;
  logic              r_e1dr;
  logic              r_ready;
  logic              r_rsp_valid;

  state_t            w_state_nx;
  logic [PH_W-1:0]   w_phase_nx;
  logic [BIT_W-1:0]  w_bit_nx;
  logic              w_accept;

  // Next-state / next-counter logic. Outputs are registered from these values
  // so every strobe and vji_tck change lands on the same edge as the state.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_bit_nx   = r_bit;
    w_accept   = 1'b0;
    if (r_state == S_IDLE) begin
      if (cmd_valid) begin
        w_accept   = 1'b1;
        w_state_nx = S_UIR;
        w_phase_nx = '0;
        w_bit_nx   = '0;
      end
    end else if (r_phase == PH_LAST) begin
      w_phase_nx = '0;
      case (r_state)
        S_UIR: w_state_nx = S_CDR;
        S_CDR: begin
          w_state_nx = S_SDR;
          w_bit_nx   = '0;
        end
        S_SDR: begin
          // Bit counter saturates on the last bit; E1DR follows directly.
          if (r_bit == BIT_LAST) w_state_nx = S_E1DR;
          else                   w_bit_nx   = r_bit + BIT_W'(1);
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else begin
      w_phase_nx = r_phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit       <= '0;
      r_ir        <= '0;
      r_data      <= '0;
      r_rsp       <= '0;
      r_tck       <= 1'b0;
      r_tdi       <= 1'b0;
      r_rti       <= 1'b1;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_e1dr      <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_bit   <= w_bit_nx;
      if (w_accept) begin
        r_ir   <= cmd_ir;
        r_data <= cmd_data;
      end
      if ((r_state == S_SDR) && (r_phase == PH_SAMPLE))
        r_rsp[r_bit] <= vji_tdo;
      // Low half then high half of each period; idle keeps tck low, so a
      // high half can never be cut short at scan end.
      r_tck       <= (w_state_nx != S_IDLE) && (w_phase_nx >= PH_HIGH);
      r_tdi       <= (w_state_nx == S_SDR) ? r_data[w_bit_nx] : 1'b0;
      r_rti       <= (w_state_nx == S_IDLE);
      r_uir       <= (w_state_nx == S_UIR);
      r_cdr       <= (w_state_nx == S_CDR);
      r_sdr       <= (w_state_nx == S_SDR);
      r_e1dr      <= (w_state_nx == S_E1DR);
      r_ready     <= (w_state_nx == S_IDLE);
      r_rsp_valid <= (r_state == S_E1DR) && (w_state_nx == S_IDLE);
    end
  end

  assign cmd_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp;
  assign vji_tck     = r_tck;
  assign vji_tdi     = r_tdi;
  assign vji_ir_in   = r_ir;
  assign vji_rti     = r_rti;
  assign vji_uir     = r_uir;
  assign vji_cdr     = r_cdr;
  assign vji_sdr     = r_sdr;
  assign vji_e1dr    = r_e1dr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nios_debug_vjtag_host.sv
// ----------------------------------------------------------------------------
// tb_nios_debug_vjtag_host
//
// Bench for nios_debug_vjtag_host: a default-parameter instance driven by a
// loopback / shift-out slave model, plus TCK_DIV=1 and TCK_DIV=5 instances in
// loopback. Drivers push expected responses (data and absolute cycle) into
// queues; monitors pop and compare when rsp_valid appears.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nios_debug_vjtag_host;

  localparam int W = 38;
  // {tck, tdi, ir_in[1:0], rti, uir, cdr, sdr, e1dr, cmd_ready, rsp_valid, rsp_data}
  localparam logic [48:0] RST_VEC = {4'b0000, 7'b1000010, 38'h0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_ir;
  logic [W-1:0]  cmd_data;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic [1:0]    vji_ir_in;
  logic          vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr;
  logic [2:0]    dbg_state;

  nios_debug_vjtag_host u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in),
    .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_e1dr(vji_e1dr),
    .o_dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  // loop_en: tdo follows tdi. Otherwise sl_sh shifts out LSB first, moving
  // on the tck falling edge that ends each SDR period.
  logic          loop_en;
  logic [W-1:0]  sl_sh;
  logic [W-1:0]  sl_cap;
  logic          sl_pend;
  int            tck_rises;

  assign vji_tdo = loop_en ? vji_tdi : sl_sh[0];

  always @(posedge vji_tck) begin
    tck_rises = tck_rises + 1;
    if (vji_sdr) begin
      sl_cap  = {vji_tdi, sl_cap[W-1:1]};
      sl_pend = 1'b1;
    end
  end

  always @(negedge vji_tck) begin
    if (sl_pend) begin
      sl_sh   = sl_sh >> 1;
      sl_pend = 1'b0;
    end
  end

  // ---------------- sweep DUTs (TCK_DIV = 1, 5) ----------------
  logic          sw_valid   [2];
  logic          sw_ready   [2];
  logic [1:0]    sw_ir      [2];
  logic [W-1:0]  sw_data    [2];
  logic          sw_rsp_v   [2];
  logic [W-1:0]  sw_rsp     [2];
  logic          sw_tck     [2];
  logic          sw_tdi     [2];
  logic [1:0]    sw_ir_in   [2];
  logic          sw_rti     [2];
  logic          sw_uir     [2];
  logic          sw_cdr     [2];
  logic          sw_sdr     [2];
  logic          sw_e1dr    [2];
  logic [2:0]    sw_dbg     [2];

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            exp_cyc_q[$];
  logic [W-1:0]  sw_exp_q[$];
  int            sw_cyc_q[$];
  int            sw_idx_q[$];

  int checks = 0;
  int errors = 0;
  int strobe_bad = 0;
  int sw_strobe_bad = 0;
  int ir_bad = 0;
  int tdi_bad = 0;
  logic [1:0] cur_ir = 2'd0;
  bit chk_tdi_zero = 1'b0;
  int last_accept = 0;
  int tck_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] out_vec();
    return {vji_tck, vji_tdi, vji_ir_in, vji_rti, vji_uir, vji_cdr, vji_sdr,
            vji_e1dr, cmd_ready, rsp_valid, rsp_data};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    nios_debug_vjtag_host #(.TCK_DIV(g == 0 ? 1 : 5), .DR_W(W), .IR_W(2)) u_sw (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(sw_valid[g]), .cmd_ready(sw_ready[g]),
      .cmd_ir(sw_ir[g]), .cmd_data(sw_data[g]),
      .rsp_valid(sw_rsp_v[g]), .rsp_data(sw_rsp[g]),
      .vji_tck(sw_tck[g]), .vji_tdi(sw_tdi[g]), .vji_tdo(sw_tdi[g]),
      .vji_ir_in(sw_ir_in[g]),
      .vji_rti(sw_rti[g]), .vji_uir(sw_uir[g]), .vji_cdr(sw_cdr[g]),
      .vji_sdr(sw_sdr[g]), .vji_e1dr(sw_e1dr[g]),
      .o_dbg_state(sw_dbg[g])
    );

    always @(negedge clk) begin : mon
      logic [W-1:0] d;
      int c;
      int ix;
      if (reset_n) begin
        if ($countones({sw_rti[g], sw_uir[g], sw_cdr[g], sw_sdr[g], sw_e1dr[g]}) != 1)
          sw_strobe_bad = sw_strobe_bad + 1;
        if (sw_rsp_v[g]) begin
          if (sw_exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL sw_unexpected_rsp: instance %0d data %0h with nothing expected", g, sw_rsp[g]);
          end else begin
            d  = sw_exp_q.pop_front();
            c  = sw_cyc_q.pop_front();
            ix = sw_idx_q.pop_front();
            chk($sformatf("sw%0d_rsp_inst", g), 64'(g), 64'(ix));
            chk($sformatf("sw%0d_rsp_data", g), 64'(sw_rsp[g]), 64'(d));
            chk($sformatf("sw%0d_rsp_cycle", g), 64'(cyc), 64'(c));
          end
        end
      end
    end
  end

  // ---------------- main monitor ----------------
  always @(negedge clk) begin : main_mon
    logic [W-1:0] d;
    int c;
    if (reset_n) begin
      if ($countones({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr}) != 1)
        strobe_bad = strobe_bad + 1;
      if (!vji_rti && (vji_ir_in !== cur_ir))
        ir_bad = ir_bad + 1;
      if (chk_tdi_zero && vji_sdr && (vji_tdi !== 1'b0))
        tdi_bad = tdi_bad + 1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_rsp: data %0h with nothing expected (t=%0t)", rsp_data, $time);
        end else begin
          d = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(d));
          chk("rsp_cycle", 64'(cyc), 64'(c));
          chk("rsp_cmd_ready", 64'(cmd_ready), 64'd1);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called just after a negedge. rel = hand-computed response cycle relative
  // to the accept edge; at the negedge before the accept edge, the response
  // negedge sits at cyc + rel.
  task automatic issue(input logic [1:0] ir, input logic [W-1:0] data,
                       input logic [W-1:0] exp, input bit push, input bit hold);
    int n;
    cmd_ir    = ir;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(cmd_ready), 64'd1);
    last_accept = cyc + 1;
    cur_ir      = ir;
    tck_base    = tck_rises;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 165);
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic sw_issue(input int idx, input logic [W-1:0] data, input int rel);
    sw_ir[idx]    = 2'd1;
    sw_data[idx]  = data;
    sw_valid[idx] = 1'b1;
    sw_exp_q.push_back(data);
    sw_cyc_q.push_back(cyc + rel);
    sw_idx_q.push_back(idx);
    @(posedge clk);
    #1;
    sw_valid[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sw_exp_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", 64'(exp_q.size() + sw_exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int a1;
    int tck_hi;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir    = 2'd0;
    cmd_data  = '0;
    loop_en   = 1'b1;
    sl_sh     = '0;
    sl_cap    = '0;
    sl_pend   = 1'b0;
    tck_rises = 0;
    for (int i = 0; i < 2; i++) begin
      sw_valid[i] = 1'b0;
      sw_ir[i]    = 2'd0;
      sw_data[i]  = '0;
    end

    // Reset check
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(out_vec()), 64'(RST_VEC));
    reset_n = 1'b1;
    tck_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vji_tck !== 1'b0) tck_hi++;
    end
    chk("tck_static_low", 64'(tck_hi), 64'd0);
    chk("post_reset_outputs", 64'(out_vec()), 64'(RST_VEC));

    // Single scan, loopback
    issue(2'd2, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5, 1'b1, 1'b0);
    wait_done();
    chk("tck_rises", 64'(tck_rises - tck_base), 64'd41);
    chk("slave_saw_tdi", 64'(sl_cap), 64'h2A_5A5A_A5A5);
    chk("rsp_data_hold", 64'(rsp_data), 64'h2A_5A5A_A5A5);

    // Slave shift-out capture, tdi must stay 0
    repeat (5) @(negedge clk);
    loop_en      = 1'b0;
    sl_sh        = 38'h3F_0000_0001;
    sl_pend      = 1'b0;
    chk_tdi_zero = 1'b1;
    issue(2'd1, 38'h0, 38'h3F_0000_0001, 1'b1, 1'b0);
    wait_done();
    chk_tdi_zero = 1'b0;
    chk("tdi_zero_in_sdr", 64'(tdi_bad), 64'd0);
    chk("slave_saw_zero", 64'(sl_cap), 64'h0);
    loop_en = 1'b1;

    // Back-to-back with cmd_valid held high
    repeat (5) @(negedge clk);
    issue(2'd1, 38'h01_2345_6789, 38'h01_2345_6789, 1'b1, 1'b1);
    a1 = last_accept;
    issue(2'd3, 38'h3E_DCBA_9876, 38'h3E_DCBA_9876, 1'b1, 1'b0);
    chk("b2b_accept_gap", 64'(last_accept - a1), 64'd165);
    wait_done();

    // cmd_valid toggling with junk while busy
    repeat (3) @(negedge clk);
    issue(2'd2, 38'h15_0F0F_F0F0, 38'h15_0F0F_F0F0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_ir    = 2'($urandom_range(0, 3));
      cmd_data  = {6'($urandom_range(0, 63)), 32'($urandom)};
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done();

    // Reset mid-SDR: low in cycle 60, released in cycle 70
    repeat (3) @(negedge clk);
    issue(2'd3, 38'h2A_AAAA_AAAA, 38'h0, 1'b0, 1'b0);
    while (cyc < last_accept + 59) @(negedge clk);
    chk("in_sdr_at_60", 64'(vji_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'(out_vec()), 64'(RST_VEC));
    while (cyc < last_accept + 69) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_after_reset", 64'(out_vec()), 64'(RST_VEC));
    issue(2'd2, 38'h05_DEAD_BEEF, 38'h05_DEAD_BEEF, 1'b1, 1'b0);
    wait_done();

    // Parameter sweep: TCK_DIV=1 -> cycle 83, TCK_DIV=5 -> cycle 411
    sw_issue(0, 38'h33_C3C3_3C3C, 83);
    wait_done();
    sw_issue(1, 38'h0C_1357_9BDF, 411);
    wait_done();

    repeat (5) @(negedge clk);
    chk("strobes_exclusive", 64'(strobe_bad), 64'd0);
    chk("sw_strobes_exclusive", 64'(sw_strobe_bad), 64'd0);
    chk("ir_in_during_scan", 64'(ir_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
